rv32i_fetch_unit: RTL and testbench
===================================

// Module: rv32i_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the RV32I pipeline, directly upstream of decode.
//  Owns the fetch PC and issues requests on a req/gnt/rvalid instruction-memory port.
//  Buffers returned words with their PC in a small in-order FIFO, and presents them to decode.
//  Applies pc_next_sel redirects from the control path and discards stale in-flight responses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address after reset
//  FIFO_DEPTH  2              instruction buffer entries (>=2); also caps in-flight requests
//  NOP_INSTR   32'h0000_0013  word driven on instruction_o when no valid instruction
// PORTS
//  clk_i            in   1   clock, all state on rising edge
//  reset_i          in   1   synchronous, active-high reset
//  stall_i          in   1   decode stall; holds head of buffer
//  pc_next_sel_i    in   3   RV32i_pkg SEL_PC_* encoding from control path
//  branch_target_i  in   32  taken-branch target (exec stage)
//  jal_target_i     in   32  JAL target (decode stage)
//  jalr_target_i    in   32  JALR target (decode stage)
//  imem_req_o       out  1   fetch request
//  imem_addr_o      out  32  fetch address, word aligned
//  imem_gnt_i       in   1   request accepted this cycle
//  imem_rvalid_i    in   1   response valid
//  imem_rdata_i     in   32  response word
//  instr_valid_o    out  1   instruction_o/pc_o hold a real instruction
//  instruction_o    out  32  to decode; NOP_INSTR when !instr_valid_o
//  pc_o             out  32  PC of instruction_o
//  fetch_err_o      out  1   misaligned redirect seen; sticky until reset
// BEHAVIOUR
//  - Reset (reset_i=1 at edge): fetch_pc=RESET_PC, FIFO empty, inflight=0, drop=0, state IDLE.
//    Outputs: imem_req_o=0, instr_valid_o=0, instruction_o=NOP_INSTR, pc_o=RESET_PC, fetch_err_o=0.
//  - FSM IDLE -> RUN unconditionally one cycle after reset release.
//    RUN -> ERR on an accepted redirect with target[1:0]!=0. ERR is left only by reset.
//  - Request: in RUN, imem_req_o=1 iff fifo_count+inflight+drop < FIFO_DEPTH.
//    imem_addr_o=fetch_pc. req/addr may change any cycle; a transfer occurs only on req&gnt.
//  - On req&gnt: fetch_pc+=4 (wraps mod 2^32), inflight++.
//    Memory returns exactly one rvalid per grant, in order, >=1 cycle after the grant.
//  - On rvalid: if drop>0, discard the word and decrement drop.
//    Otherwise push {pc,rdata} and decrement inflight. The pushed PC is tracked by a response-PC counter.
//    A push is visible on the outputs the next cycle, so minimum latency is gnt->rvalid->+1 cycle.
//  - Pop: head is removed when instr_valid_o & !stall_i. Push and pop in the same cycle are allowed.
//    The FIFO never overflows because of the request cap.
//  - Redirect acceptance:
//    SEL_PC_BRANCH is always honoured and overrides stall_i.
//    SEL_PC_JAL and SEL_PC_JALR are honoured only when instr_valid_o & !stall_i.
//    If BRANCH and JAL/JALR are both present, BRANCH wins.
//  - On an accepted redirect, in the same edge:
//    FIFO flushed; no pop is counted.
//    drop += inflight (+1 if req&gnt this cycle, -1 if a non-drop rvalid this cycle); inflight=0.
//    fetch_pc = target. New requests may start the next cycle.
//  - When instr_valid_o=0, instruction_o=NOP_INSTR and pc_o holds its last value.
//  - ERR state: imem_req_o=0, instr_valid_o=0, fetch_err_o=1.
//    Outstanding responses are still counted and discarded.
//  - Reset mid-operation: all counters clear. Responses arriving after reset are ignored;
//    the memory is reset on the same reset_i.
// TESTING
//  1 Reset 3 cyc, mem gnt=1, rvalid 1 cyc later, rdata=PC -> req at 0x0,4,8...;
//    instr_valid_o first at cycle 3 after release with pc_o=0x0, then one instruction per cycle.
//  2 stall_i=1 for 4 cyc while streaming -> instruction_o/pc_o frozen; req drops once
//    fifo+inflight=FIFO_DEPTH; resumes with no lost or duplicated PC.
//  3 gnt delayed 3 cyc at addr 0x10 -> imem_req_o held, no pc change;
//    fetch continues at 0x14 after grant.
//  4 SEL_PC_BRANCH target 0x100 with 2 requests in flight and stall_i=1 ->
//    both stale responses discarded; next valid pc_o=0x100, instr 0x100.
//  5 SEL_PC_JALR target 0x102 -> fetch_err_o=1 next cycle; req and valid stay 0 until reset_i.
//  6 reset_i pulsed with 2 in flight -> outputs return to reset values the next cycle;
//    fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit
//   Instruction-fetch stage feeding decode. Owns the fetch PC, issues word
//   requests on a req/gnt/rvalid instruction-memory port, buffers returned
//   words together with their PC in a small in-order FIFO and presents the
//   head to decode. Control-path redirects (branch/JAL/JALR) flush the
//   buffer; responses that were already in flight are counted and dropped.
//
// Ports
//   clk_i, reset_i      clock / synchronous active-high reset
//   stall_i             decode stall, holds the buffer head
//   pc_next_sel_i       redirect select (SEL_PC_* encoding below)
//   branch_target_i     taken-branch target
//   jal_target_i        JAL target
//   jalr_target_i       JALR target
//   imem_req_o/addr_o   fetch request and word address
//   imem_gnt_i          request accepted this cycle
//   imem_rvalid_i/rdata response valid and word (in order, one per grant)
//   instr_valid_o       instruction_o/pc_o hold a real instruction
//   instruction_o       head word, NOP_INSTR when not valid
//   pc_o                PC of head word, last value when not valid
//   fetch_err_o         misaligned redirect seen, sticky until reset
//
// pc_next_sel_i encoding: 0 = sequential (no redirect), 1 = BRANCH,
// 2 = JAL, 3 = JALR; any other value is treated as sequential.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | one cycle after reset release, no requests
// ST_RUN   | normal fetching
// ST_ERR   | misaligned redirect seen; no requests, no output, until reset

module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic [2:0]  pc_next_sel_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jal_target_i,
  input  logic [31:0] jalr_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        fetch_err_o
);

  localparam logic [2:0] SEL_PC_BRANCH = 3'd1;
  localparam logic [2:0] SEL_PC_JAL    = 3'd2;
  localparam logic [2:0] SEL_PC_JALR   = 3'd3;

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int unsigned OW = CW + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    resp_pc_q, resp_pc_d;
  logic [31:0]    pc_last_q, pc_last_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]    fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]    fifo_pc_d   [FIFO_DEPTH];
  logic [31:0]    fifo_word_q [FIFO_DEPTH];
  logic [31:0]    fifo_word_d [FIFO_DEPTH];

  logic           in_run;
  logic           head_valid;
  logic           pop_ok;
  logic           take_branch;
  logic           take_jump;
  logic           redir;
  logic [31:0]    redir_target;
  logic           redir_misaligned;
  logic [OW-1:0]  occupancy;
  logic           req;
  logic           xfer;
  logic           rv_drop;
  logic           rv_keep;
  logic           push;
  logic           pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  if (redir && redir_misaligned) state_d = ST_ERR;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- control decode ----------------
  always_comb begin
    in_run      = (state_q == ST_RUN);
    head_valid  = in_run && (count_q != '0);
    pop_ok      = head_valid && !stall_i;
    // Branches resolve in exec and must win over a stalled decode;
    // jumps resolve in decode, so they only count when the head moves.
    take_branch = in_run && (pc_next_sel_i == SEL_PC_BRANCH);
    take_jump   = pop_ok && ((pc_next_sel_i == SEL_PC_JAL) ||
                             (pc_next_sel_i == SEL_PC_JALR));
    redir       = take_branch || take_jump;
    if (take_branch)                        redir_target = branch_target_i;
    else if (pc_next_sel_i == SEL_PC_JAL)   redir_target = jal_target_i;
    else                                    redir_target = jalr_target_i;
    redir_misaligned = (redir_target[1:0] != 2'b00);

    // Stale responses still occupy slots until they come back, so they
    // count against the request cap together with buffered and live ones.
    occupancy = OW'(count_q) + OW'(inflight_q) + OW'(drop_q);
    req       = in_run && (occupancy < OW'(FIFO_DEPTH));
    xfer      = req && imem_gnt_i;
    rv_drop   = imem_rvalid_i && (drop_q != '0);
    rv_keep   = imem_rvalid_i && (drop_q == '0) && (inflight_q != '0);
    push      = rv_keep && in_run && !redir;
    pop       = pop_ok && !redir;
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    pc_last_d   = head_valid ? fifo_pc_q[rd_ptr_q] : pc_last_q;
    inflight_d  = inflight_q + CW'(xfer) - CW'(rv_keep);
    drop_d      = drop_q - CW'(rv_drop);
    count_d     = count_q + CW'(push) - CW'(pop);
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_word_d = fifo_word_q;

    if (xfer) fetch_pc_d = fetch_pc_q + 32'd4;

    if (push) begin
      fifo_pc_d[wr_ptr_q]   = resp_pc_q;
      fifo_word_d[wr_ptr_q] = imem_rdata_i;
      resp_pc_d             = resp_pc_q + 32'd4;
    end

    if (redir) begin
      // Everything still owed by memory becomes stale, including a grant
      // taken this very edge; a live response arriving now is simply lost
      // with the flush and so is not added.
      drop_d     = drop_q - CW'(rv_drop) + inflight_q + CW'(xfer) - CW'(rv_keep);
      inflight_d = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redir_target;
      resp_pc_d  = redir_target;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      pc_last_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      pc_last_q  <= pc_last_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer storage needs no reset: entries are only read behind count_q.
  always_ff @(posedge clk_i) begin
    fifo_pc_q   <= fifo_pc_d;
    fifo_word_q <= fifo_word_d;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    imem_req_o    = req;
    imem_addr_o   = fetch_pc_q;
    instr_valid_o = head_valid;
    instruction_o = head_valid ? fifo_word_q[rd_ptr_q] : NOP_INSTR;
    pc_o          = head_valid ? fifo_pc_q[rd_ptr_q]   : pc_last_q;
    fetch_err_o   = (state_q == ST_ERR);
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Bench for rv32i_fetch_unit: directed scenarios followed by a randomized
// run, all checked every cycle against a transaction-level reference model.

module tb_rv32i_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam logic [2:0] SEL_PLUS4  = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JAL    = 3'd2;
  localparam logic [2:0] SEL_JALR   = 3'd3;

  logic        clk = 1'b0;
  logic        reset_i, stall_i;
  logic [2:0]  pc_next_sel_i;
  logic [31:0] branch_target_i, jal_target_i, jalr_target_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        instr_valid_o, fetch_err_o;
  logic [31:0] instruction_o, pc_o;

  always #5 clk = ~clk;

  rv32i_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .stall_i        (stall_i),
    .pc_next_sel_i  (pc_next_sel_i),
    .branch_target_i(branch_target_i),
    .jal_target_i   (jal_target_i),
    .jalr_target_i  (jalr_target_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_valid_o  (instr_valid_o),
    .instruction_o  (instruction_o),
    .pc_o           (pc_o),
    .fetch_err_o    (fetch_err_o)
  );

  typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;
  typedef struct { logic [31:0] addr; bit keep; }        pend_t;
  typedef struct { logic [31:0] addr; int due; }         mreq_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int gnt_mode = 1;             // 0 never, 1 always, 2 random
  int lat_min = 1, lat_max = 1;

  // reference model: buffer of {pc,word}, list of outstanding fetches
  bit          m_started, m_err;
  logic [31:0] m_pc, m_last_pc;
  ent_t        m_buf[$];
  pend_t       m_out[$];
  mreq_t       mq[$];           // memory side: granted, not yet returned

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_run();
    return m_started && !m_err;
  endfunction
  function automatic bit m_valid();
    return m_run() && (m_buf.size() > 0);
  endfunction
  function automatic bit m_req();
    return m_run() && ((m_buf.size() + m_out.size()) < DEPTH);
  endfunction

  task automatic model_reset();
    m_started = 0; m_err = 0;
    m_pc = RESET_PC; m_last_pc = RESET_PC;
    m_buf.delete(); m_out.delete();
  endtask

  task automatic model_edge();
    bit valid, gx, br, jp, redir;
    logic [31:0] tgt;
    pend_t p;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    valid = m_valid();
    gx    = m_req() && imem_gnt_i;
    br    = m_run() && (pc_next_sel_i == SEL_BRANCH);
    jp    = valid && !stall_i && (pc_next_sel_i == SEL_JAL || pc_next_sel_i == SEL_JALR);
    redir = br || jp;
    tgt   = br ? branch_target_i : (pc_next_sel_i == SEL_JAL ? jal_target_i : jalr_target_i);
    if (valid) m_last_pc = m_buf[0].pc;
    if (valid && !stall_i && !redir) void'(m_buf.pop_front());
    if (imem_rvalid_i && m_out.size() > 0) begin
      p = m_out.pop_front();
      if (p.keep && !redir) m_buf.push_back('{pc: p.addr, word: imem_rdata_i});
    end
    if (gx) begin
      m_out.push_back('{addr: m_pc, keep: 1'b1});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      foreach (m_out[i]) m_out[i].keep = 1'b0;
      m_buf.delete();
      m_pc = tgt;
      if (tgt[1:0] != 2'b00) m_err = 1;
    end
  endtask

  // One clock cycle: drive memory, compare, advance model, take the edge.
  task automatic tick();
    bit dreq;
    logic [31:0] daddr;
    int lat;
    case (gnt_mode)
      0:       imem_gnt_i = 1'b0;
      1:       imem_gnt_i = 1'b1;
      default: imem_gnt_i = 1'($urandom_range(0, 1));
    endcase
    if (!reset_i && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mq[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    check("req", 32'(imem_req_o), 32'(m_req()));
    if (m_req()) check("addr", imem_addr_o, m_pc);
    check("valid", 32'(instr_valid_o), 32'(m_valid()));
    if (m_valid()) begin
      check("instr", instruction_o, m_buf[0].word);
      check("pc", pc_o, m_buf[0].pc);
    end else begin
      check("instr_nop", instruction_o, NOP);
      check("pc_hold", pc_o, m_last_pc);
    end
    check("err", 32'(fetch_err_o), 32'(m_err));
    dreq  = imem_req_o;
    daddr = imem_addr_o;
    if (reset_i) model_reset();
    else         model_edge();
    @(posedge clk);
    if (reset_i) mq.delete();
    else begin
      if (imem_rvalid_i) void'(mq.pop_front());
      if (dreq && imem_gnt_i) begin
        lat = $urandom_range(lat_min, lat_max);
        mq.push_back('{addr: daddr, due: cyc + lat});
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req_o),    32'd0);
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    check({tag, "_instr"}, instruction_o,      NOP);
    check({tag, "_pc"},    pc_o,               RESET_PC);
    check({tag, "_err"},   32'(fetch_err_o),   32'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    int first_valid;
    int n;
    int err_cycles;
    int r;
    reset_i = 1'b1; stall_i = 1'b0; pc_next_sel_i = SEL_PLUS4;
    branch_target_i = '0; jal_target_i = '0; jalr_target_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    @(negedge clk);
    model_reset();

    // 1: reset 3 cycles, streaming with gnt=1 and 1-cycle latency
    gnt_mode = 1; lat_min = 1; lat_max = 1;
    repeat (2) tick();
    check_reset_outputs("t1_rst");
    reset_i = 1'b0;
    first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      if (first_valid < 0 && instr_valid_o) begin
        first_valid = i;
        check("t1_first_pc", pc_o, RESET_PC);
        check("t1_first_instr", instruction_o, mem_word(RESET_PC));
      end
      tick();
    end
    check("t1_first_valid_cycle", 32'(first_valid), 32'd3);

    // 2: decode stall for 4 cycles while streaming
    stall_i = 1'b1;
    repeat (4) tick();
    stall_i = 1'b0;
    repeat (8) tick();

    // 3: grant withheld 3 cycles at 0x10
    do_reset();
    n = 0;
    while (imem_addr_o != 32'h10 && n < 40) begin tick(); n++; end
    check("t3_reach_0x10", imem_addr_o, 32'h10);
    gnt_mode = 0;
    repeat (3) tick();
    check("t3_hold_addr", imem_addr_o, 32'h10);
    gnt_mode = 1;
    repeat (8) tick();

    // 4: branch to 0x100 with two fetches in flight and decode stalled
    lat_min = 3; lat_max = 3;
    do_reset();
    stall_i = 1'b1;
    repeat (3) tick();
    check("t4_cap_req", 32'(imem_req_o), 32'd0);
    pc_next_sel_i = SEL_BRANCH; branch_target_i = 32'h100;
    tick();
    pc_next_sel_i = SEL_PLUS4; stall_i = 1'b0;
    n = 0;
    while (!instr_valid_o && n < 20) begin tick(); n++; end
    check("t4_wait_valid", 32'(instr_valid_o), 32'd1);
    check("t4_pc", pc_o, 32'h100);
    check("t4_instr", instruction_o, mem_word(32'h100));
    repeat (6) tick();

    // 5: misaligned JALR
    lat_min = 1; lat_max = 1;
    do_reset();
    n = 0;
    while (!instr_valid_o && n < 20) begin tick(); n++; end
    check("t5_wait_valid", 32'(instr_valid_o), 32'd1);
    pc_next_sel_i = SEL_JALR; jalr_target_i = 32'h102;
    tick();
    pc_next_sel_i = SEL_PLUS4;
    check("t5_err", 32'(fetch_err_o), 32'd1);
    repeat (5) begin
      check("t5_req_low", 32'(imem_req_o), 32'd0);
      check("t5_valid_low", 32'(instr_valid_o), 32'd0);
      tick();
    end

    // 6: reset pulse with two fetches in flight
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (3) tick();
    do_reset();
    check_reset_outputs("t6_rst");
    tick();
    check("t6_restart_req", 32'(imem_req_o), 32'd1);
    check("t6_restart_addr", imem_addr_o, RESET_PC);
    repeat (8) tick();

    // randomized traffic
    gnt_mode = 2; lat_min = 1; lat_max = 4;
    err_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 23);
      pc_next_sel_i = (r == 0) ? SEL_BRANCH : (r == 1) ? SEL_JAL :
                      (r == 2) ? SEL_JALR   : (r == 3) ? 3'd5    : SEL_PLUS4;
      branch_target_i = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      jal_target_i    = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      jalr_target_i   = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      if ($urandom_range(0, 59) == 0) branch_target_i[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 59) == 0) jalr_target_i[1:0]   = 2'($urandom_range(1, 3));
      err_cycles = m_err ? err_cycles + 1 : 0;
      reset_i = (err_cycles > 4) || ($urandom_range(0, 399) == 0);
      tick();
    end
    reset_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
